tone_generator: RTL and testbench

TONE_GENERATOR -- requirements
Module: tone_generator

---
 rtl/tone_pkg.sv | 18 +
 rtl/tone_generator_if.sv | 13 +
 rtl/tone_divider.sv | 28 ++
 rtl/tone_generator.sv | 112 +++++++++++
 tb/tb_tone_generator.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/tone_pkg.sv
// tone_pkg: FSM states, widths and the octave-0 note half-period table (10 MHz clock, C4..B4)
package tone_pkg;
    localparam int NOTE_W = 4;
    localparam int DIV_W = 16;
    typedef enum logic [1:0] {IDLE, DEBOUNCE, PLAY, RELEASE} tone_state_e;
    // Half-periods in clock cycles, round(5e6 / f)
    localparam logic [DIV_W-1:0] NOTE_HALF_PERIOD [12] = '{
        16'd19111, 16'd18039, 16'd17026, 16'd16071, 16'd15169, 16'd14317,
        16'd13514, 16'd12755, 16'd12039, 16'd11364, 16'd10726, 16'd10124
    };
    function automatic logic is_rest(input logic [NOTE_W-1:0] note);
        return note >= NOTE_W'(12);
    endfunction
    // Rests pace their re-sampling with the C half-period of the selected octave
    function automatic logic [DIV_W-1:0] half_period(input logic [NOTE_W-1:0] note, input logic [1:0] octave);
        return (is_rest(note) ? NOTE_HALF_PERIOD[0] : NOTE_HALF_PERIOD[note]) >> octave;
    endfunction
endpackage

// File: rtl/tone_generator_if.sv
// tone_generator_if: key/note/LFO controls in; tone, tremolo and activity flags out
interface tone_generator_if;
    import tone_pkg::*;
    logic key_i;
    logic [NOTE_W-1:0] note_i;
    logic [1:0] octave_i;
    logic [1:0] lfo_rate_i;
    logic tone_o;
    logic lfo_o;
    logic active_o;
    modport master (output key_i, note_i, octave_i, lfo_rate_i, input tone_o, lfo_o, active_o);
    modport slave (input key_i, note_i, octave_i, lfo_rate_i, output tone_o, lfo_o, active_o);
endinterface

// File: rtl/tone_divider.sv
// tone_divider: half-period down-counter and square-wave flop; strobe marks each reload
module tone_divider
    import tone_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             hold,
    input  logic [DIV_W-1:0] load_val,
    output logic             sq,
    output logic             strobe
);
    logic [DIV_W-1:0] cnt;
    assign strobe = en && !load && cnt == '0;
    // A rest parks the output low while the counter keeps pacing re-samples
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
            sq <= 1'b0;
        end else if (load || strobe) begin
            cnt <= load_val;
            sq <= !hold && (load || !sq);
        end else begin
            cnt <= cnt - DIV_W'(1);
        end
    end
endmodule

// File: rtl/tone_generator.sv
// tone_generator: debounced key starts a square-wave note with a release tail and tremolo LFO.
// The LFO exists only when TONE_GENERATOR_LFO_EN is defined; otherwise lfo_o is tied low.
module tone_generator
    import tone_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 16,
    parameter int RELEASE_CYC = 1024,
    parameter int LFO_SHIFT = 10
) (
    input logic clk,
    input logic rst,
    tone_generator_if.slave bus
);
    localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int REL_W = $clog2(RELEASE_CYC + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYC - 1);
    tone_state_e state_q, state_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [REL_W-1:0] rel_q, rel_d;
    logic start, active_d, strobe, sample;
    logic [NOTE_W-1:0] note_q, note_n;
    logic [1:0] oct_q, oct_n;
    always_comb begin
        state_d = state_q;
        deb_d = deb_q;
        rel_d = rel_q;
        start = 1'b0;
        case (state_q)
            IDLE: if (bus.key_i) begin
                state_d = DEBOUNCE;
                deb_d = DEB_W'(1);
            end
            DEBOUNCE: if (!bus.key_i) begin
                state_d = IDLE;
                deb_d = '0;
            end else if (deb_q >= DEB_LAST) begin
                state_d = PLAY;
                deb_d = '0;
                start = 1'b1;
            end else begin
                deb_d = deb_q + DEB_W'(1);
            end
            PLAY: if (!bus.key_i) begin
                state_d = RELEASE;
                rel_d = REL_W'(1);
            end
            RELEASE: if (bus.key_i) begin
                state_d = PLAY;
                rel_d = '0;
            end else if (rel_q >= REL_LAST) begin
                state_d = IDLE;
                rel_d = '0;
            end else begin
                rel_d = rel_q + REL_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    assign active_d = state_d == PLAY || state_d == RELEASE;
    // Note and octave are taken only at start or at a tone reload, keeping edges glitch-free
    assign sample = start || strobe;
    assign note_n = sample ? bus.note_i : note_q;
    assign oct_n = sample ? bus.octave_i : oct_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            deb_q <= '0;
            rel_q <= '0;
            note_q <= '0;
            oct_q <= '0;
            bus.active_o <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q <= deb_d;
            rel_q <= rel_d;
            note_q <= note_n;
            oct_q <= oct_n;
            bus.active_o <= active_d;
        end
    end
    tone_divider u_div (
        .clk(clk),
        .rst(rst),
        .en(active_d),
        .load(start),
        .hold(is_rest(note_n)),
        .load_val(half_period(note_n, oct_n) - DIV_W'(1)),
        .sq(bus.tone_o),
        .strobe(strobe)
    );
`ifdef TONE_GENERATOR_LFO_EN
    localparam int LFO_W = LFO_SHIFT + 3;
    logic [LFO_W-1:0] lfo_cnt;
    logic [1:0] rate_q;
    logic lfo_end;
    assign lfo_end = bus.active_o && lfo_cnt == ({LFO_W{1'b1}} >> (2'd3 - rate_q));
    // Rate is captured while inactive (so the first half-period uses the rate at start) and at each toggle
    always_ff @(posedge clk) begin
        if (rst || !active_d) begin
            lfo_cnt <= '0;
            bus.lfo_o <= 1'b0;
        end else if (bus.active_o) begin
            lfo_cnt <= lfo_end ? '0 : lfo_cnt + LFO_W'(1);
            bus.lfo_o <= bus.lfo_o ^ lfo_end;
        end
        rate_q <= rst ? 2'd0 : (!bus.active_o || lfo_end) ? bus.lfo_rate_i : rate_q;
    end
`else
    assign bus.lfo_o = 1'b0;
`endif
endmodule

// File: tb/tb_tone_generator.sv
// tb_tone_generator: vector table, directed corner sequences and random play checked
// against a timestamp-based reference model of the note, release and LFO behaviour
module tb_tone_generator;
    localparam int DEB = 4;
    localparam int REL = 8;
    localparam int SHIFT = 2;
`ifdef TONE_GENERATOR_LFO_EN
    localparam bit LFO_ON = 1'b1;
`else
    localparam bit LFO_ON = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    tone_generator_if bus();
    tone_generator #(.DEBOUNCE_CYC(DEB), .RELEASE_CYC(REL), .LFO_SHIFT(SHIFT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit m_act, m_tone, m_lfo;
    int m_run, m_low, m_next, m_lnext;
    typedef struct {int r; int k; int note; int t; int a;} vec_t;
    vec_t vecs[17];
    // Equal-tempered pitch from A4 = 440 Hz, half-period = round(5e6 / f) shifted by octave
    function automatic int ref_half(input int note, input int oct);
        real f;
        f = 440.0 * (2.0 ** (real'((note >= 12 ? 0 : note) - 9) / 12.0));
        return $rtoi(5.0e6 / f + 0.5) >> oct;
    endfunction
    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask
    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask
    // Reference: key run lengths decide start/stop; tone and LFO events are absolute cycle stamps
    task automatic model_edge();
        cyc++;
        if (rst) begin
            m_act = 0; m_tone = 0; m_lfo = 0; m_run = 0; m_low = 0;
        end else if (!m_act) begin
            m_run = bus.key_i ? m_run + 1 : 0;
            if (m_run == DEB) begin
                m_act = 1; m_run = 0; m_low = 0; m_lfo = 0;
                m_tone = bus.note_i < 12;
                m_next = cyc + ref_half(int'(bus.note_i), int'(bus.octave_i));
                m_lnext = cyc + (1 << (SHIFT + int'(bus.lfo_rate_i)));
            end
        end else begin
            m_low = bus.key_i ? 0 : m_low + 1;
            if (m_low == REL) begin
                m_act = 0; m_tone = 0; m_lfo = 0; m_low = 0;
            end else begin
                if (cyc == m_next) begin
                    m_tone = bus.note_i < 12 && !m_tone;
                    m_next = cyc + ref_half(int'(bus.note_i), int'(bus.octave_i));
                end
                if (cyc == m_lnext) begin
                    m_lfo = !m_lfo;
                    m_lnext = cyc + (1 << (SHIFT + int'(bus.lfo_rate_i)));
                end
            end
        end
    endtask
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("tone", bus.tone_o, m_tone);
        chk("active", bus.active_o, m_act);
        chk("lfo", bus.lfo_o, LFO_ON & m_lfo);
    endtask
    task automatic measure(input bit lfo, input int lim, output int n);
        logic v0;
        v0 = lfo ? bus.lfo_o : bus.tone_o;
        n = 0;
        do begin
            tick();
            n++;
        end while ((lfo ? bus.lfo_o : bus.tone_o) === v0 && n < lim);
    endtask
    initial begin
        int n, len;
        rst = 1'b1;
        bus.key_i = 1'b0;
        bus.note_i = 4'd9;
        bus.octave_i = 2'd0;
        bus.lfo_rate_i = 2'd0;
        vecs = '{'{1, 0, 9, 0, 0}, '{0, 1, 9, 0, 0}, '{0, 1, 9, 0, 0}, '{0, 1, 9, 0, 0},
                 '{0, 1, 9, 1, 1}, '{0, 0, 9, 1, 1}, '{0, 1, 9, 1, 1}, '{1, 1, 9, 0, 0},
                 '{0, 1, 9, 0, 0}, '{0, 1, 9, 0, 0}, '{0, 1, 9, 0, 0}, '{0, 0, 9, 0, 0},
                 '{0, 1, 13, 0, 0}, '{0, 1, 13, 0, 0}, '{0, 1, 13, 0, 0}, '{0, 1, 13, 0, 1},
                 '{0, 0, 13, 0, 1}};
        for (int i = 0; i < 17; i++) begin
            rst = 1'(vecs[i].r);
            bus.key_i = 1'(vecs[i].k);
            bus.note_i = 4'(vecs[i].note);
            tick();
            chk("vec_tone", bus.tone_o, 1'(vecs[i].t));
            chk("vec_active", bus.active_o, 1'(vecs[i].a));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.key_i = 1'b1;
        bus.note_i = 4'd9;
        repeat (DEB) tick();
        chk("a_start_tone", bus.tone_o, 1'b1);
        chk("a_start_active", bus.active_o, 1'b1);
        measure(0, 20000, n);
        chk_int("a_half_a", n, 11364);
        repeat (100) tick();
        bus.note_i = 4'd0;
        measure(0, 20000, n);
        chk_int("a_latched_a", n, 11264);
        repeat (5000) tick();
        bus.note_i = 4'd9;
        measure(0, 20000, n);
        chk_int("a_half_c", n, 14111);
        bus.key_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("b_release_active", bus.active_o, 1'b1);
        end
        bus.key_i = 1'b1;
        tick();
        chk("b_repress_active", bus.active_o, 1'b1);
        measure(0, 20000, n);
        chk_int("b_phase_kept", n, 11358);
        bus.key_i = 1'b0;
        repeat (REL - 1) tick();
        chk("b_tail_active", bus.active_o, 1'b1);
        tick();
        chk("b_idle_active", bus.active_o, 1'b0);
        chk("b_idle_tone", bus.tone_o, 1'b0);
        chk("b_idle_lfo", bus.lfo_o, 1'b0);
        bus.key_i = 1'b1;
        bus.note_i = 4'd0;
        bus.octave_i = 2'd3;
        repeat (DEB) tick();
        measure(0, 5000, n);
        chk_int("c_half_oct3", n, 2388);
        measure(0, 5000, n);
        chk_int("c_half_oct3_b", n, 2388);
        bus.note_i = 4'd13;
        measure(0, 5000, n);
        chk_int("c_rest_entry", n, 2388);
        repeat (3000) tick();
        chk("c_rest_tone", bus.tone_o, 1'b0);
        chk("c_rest_active", bus.active_o, 1'b1);
        bus.note_i = 4'd0;
        measure(0, 5000, n);
        chk_int("c_rest_exit", n, 1776);
        chk("c_rest_exit_tone", bus.tone_o, 1'b1);
        rst = 1'b1;
        tick();
        chk("d_rst_tone", bus.tone_o, 1'b0);
        chk("d_rst_active", bus.active_o, 1'b0);
        chk("d_rst_lfo", bus.lfo_o, 1'b0);
        rst = 1'b0;
        bus.lfo_rate_i = 2'd1;
        repeat (DEB) tick();
        measure(1, 40, n);
        chk_int("d_lfo_half", n, LFO_ON ? 8 : 40);
        measure(1, 40, n);
        chk_int("d_lfo_half_b", n, LFO_ON ? 8 : 40);
        for (int s = 0; s < 40; s++) begin
            bus.key_i = 1'($urandom_range(0, 1));
            bus.note_i = 4'($urandom_range(0, 15));
            bus.octave_i = 2'($urandom_range(2, 3));
            bus.lfo_rate_i = 2'($urandom_range(0, 3));
            rst = $urandom_range(0, 19) == 0;
            if (rst) begin
                tick();
                rst = 1'b0;
            end
            len = bus.key_i ? $urandom_range(1, 600) : $urandom_range(1, 12);
            repeat (len) tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
